// File: rtl/branch_info_queue.sv
// Branch info queue: holds IF-stage prediction context (PC, history snapshot,
// predicted direction) in program order until the branch resolves in EX.
// On a resolve the oldest entry is popped and checked against the outcome. A
// mispredict empties the queue and produces the corrected history one cycle
// later. Prediction hit/miss statistics are kept alongside.
module branch_info_queue #(
  parameter int DEPTH = 4,
  parameter int BHR_W = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [31:0]                push_pc,
  input  logic [BHR_W-1:0]           push_bhr,
  input  logic                       push_pred_taken,
  output logic                       push_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [31:0]                head_pc,
  output logic [BHR_W-1:0]           head_bhr,
  output logic                       head_pred_taken,
  output logic                       mispredict,
  output logic [BHR_W-1:0]           restore_bhr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage is never reset; head_* are only meaningful with head_valid.
  logic [31:0]      pc_mem   [DEPTH];
  logic [BHR_W-1:0] bhr_mem  [DEPTH];
  logic             pred_mem [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mispredict_q, mispredict_d;
  logic [BHR_W-1:0] restore_bhr_q, restore_bhr_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty;
  logic pop, hit, miss, push_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Flush outranks resolve: a flushing cycle never pops or scores.
  assign pop  = resolve_valid && !empty && !flush;
  assign hit  = pop && (resolve_taken == pred_mem[rd_ptr_q]);
  assign miss = pop && (resolve_taken != pred_mem[rd_ptr_q]);
  // A push behind a mispredict is wrong-path, so it is discarded like on flush.
  assign push_acc = push_valid && !flush && !miss && (!full || pop);

  // Next-state: pointers, occupancy, statistics, error flags, recovery outputs.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mispredict_d  = miss;
    restore_bhr_d = restore_bhr_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (flush || miss) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push_acc, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (miss) restore_bhr_d = {bhr_mem[rd_ptr_q][BHR_W-2:0], resolve_taken};

    if (hit  && hit_cnt_q  != 16'hFFFF) hit_cnt_d  = hit_cnt_q  + 16'd1;
    if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;

    if (push_valid && full && !pop && !flush) overflow_d  = 1'b1;
    if (resolve_valid && empty && !flush)     underflow_d = 1'b1;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      mispredict_q  <= 1'b0;
      restore_bhr_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mispredict_q  <= mispredict_d;
      restore_bhr_q <= restore_bhr_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Entry write at the tail; a full-queue pop+push reuses the slot just read.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      bhr_mem[wr_ptr_q]  <= push_bhr;
      pred_mem[wr_ptr_q] <= push_pred_taken;
    end
  end

  assign push_ready      = !full;
  assign head_valid      = !empty;
  assign head_pc         = pc_mem[rd_ptr_q];
  assign head_bhr        = bhr_mem[rd_ptr_q];
  assign head_pred_taken = pred_mem[rd_ptr_q];
  assign mispredict      = mispredict_q;
  assign restore_bhr     = restore_bhr_q;
  assign count           = count_q;
  assign overflow_err    = overflow_q;
  assign underflow_err   = underflow_q;
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;
endmodule

// File: tb/tb_branch_info_queue.sv
// Directed bench for branch_info_queue: basic hit, overflow, full-queue
// wrap, mispredict recovery, flush priority, async reset and underflow.
module tb_branch_info_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_pred_taken, push_ready;
  logic [31:0] push_pc;
  logic [6:0]  push_bhr;
  logic        resolve_valid, resolve_taken, flush;
  logic        head_valid, head_pred_taken, mispredict;
  logic [31:0] head_pc;
  logic [6:0]  head_bhr, restore_bhr;
  logic [2:0]  count;
  logic        overflow_err, underflow_err;
  logic [15:0] hit_cnt, miss_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];

  branch_info_queue #(.DEPTH(4), .BHR_W(7)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_bhr(push_bhr),
    .push_pred_taken(push_pred_taken), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .head_valid(head_valid), .head_pc(head_pc), .head_bhr(head_bhr),
    .head_pred_taken(head_pred_taken), .mispredict(mispredict),
    .restore_bhr(restore_bhr), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 0; resolve_valid = 0; flush = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [6:0] bhr, input logic pred);
    idle();
    push_valid = 1; push_pc = pc; push_bhr = bhr; push_pred_taken = pred;
    tick();
    idle();
  endtask

  task automatic resolve(input logic taken);
    idle();
    resolve_valid = 1; resolve_taken = taken;
    tick();
    idle();
  endtask

  initial begin
    rst = 0; idle(); push_pc = 0; push_bhr = 0; push_pred_taken = 0; resolve_taken = 0;
    #12;
    chk("rst_ready", push_ready, 1);
    chk("rst_hvalid", head_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_ovf", overflow_err, 0);
    rst = 1;
    tick();

    // Single correct prediction
    push(32'h100, 7'h05, 1);
    chk("p1_count", count, 1);
    chk("p1_pc", head_pc, 32'h100);
    chk("p1_bhr", head_bhr, 7'h05);
    chk("p1_pred", head_pred_taken, 1);
    resolve(1);
    chk("p1_count0", count, 0);
    chk("p1_hit", hit_cnt, 1);
    chk("p1_misp", mispredict, 0);
    chk("p1_miss", miss_cnt, 0);

    // Overflow: fifth push while full is dropped
    for (int i = 0; i < 4; i++) push(32'h200 + 4 * i, 7'(i), 1);
    chk("ov_count4", count, 4);
    chk("ov_ready", push_ready, 0);
    chk("ov_err0", overflow_err, 0);
    push(32'h2FF, 7'h7F, 1);
    chk("ov_err", overflow_err, 1);
    chk("ov_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("ov_order", head_pc, 32'h200 + 4 * i);
      resolve(1);
    end
    chk("ov_empty", head_valid, 0);
    chk("ov_hit", hit_cnt, 5);

    // Full queue: simultaneous correct pop and push, pointers wrap
    for (int i = 0; i < 4; i++) begin
      push(32'h300 + i, 7'(i), 0);
      exp_q.push_back(32'h300 + i);
    end
    for (int k = 0; k < 8; k++) begin
      chk("wr_head", head_pc, exp_q.pop_front());
      push_valid = 1; push_pc = 32'h400 + k; push_bhr = 7'(k); push_pred_taken = 0;
      resolve_valid = 1; resolve_taken = 0;
      tick();
      idle();
      exp_q.push_back(32'h400 + k);
      chk("wr_count", count, 4);
    end
    for (int i = 0; i < 4; i++) begin
      chk("wr_drain", head_pc, exp_q.pop_front());
      resolve(0);
    end
    chk("wr_hit", hit_cnt, 17);
    chk("wr_count0", count, 0);

    // Mispredict: queue emptied, corrected history next cycle
    push(32'h500, 7'h2A, 1);
    push(32'h504, 7'h11, 0);
    push(32'h508, 7'h12, 0);
    idle();
    push_valid = 1; push_pc = 32'h50C; push_bhr = 7'h13; push_pred_taken = 0;
    resolve_valid = 1; resolve_taken = 0;
    tick();
    idle();
    chk("mp_pulse", mispredict, 1);
    chk("mp_restore", restore_bhr, 7'h54);
    chk("mp_count", count, 0);
    chk("mp_miss", miss_cnt, 1);
    chk("mp_hit", hit_cnt, 17);
    tick();
    chk("mp_pulse_end", mispredict, 0);
    chk("mp_restore_hold", restore_bhr, 7'h54);

    // Flush beats resolve and push
    push(32'h600, 7'h01, 1);
    push(32'h604, 7'h02, 1);
    flush = 1; resolve_valid = 1; resolve_taken = 0;
    push_valid = 1; push_pc = 32'h608; push_pred_taken = 1;
    tick();
    idle();
    chk("fl_count", count, 0);
    chk("fl_hvalid", head_valid, 0);
    chk("fl_misp", mispredict, 0);
    chk("fl_hit", hit_cnt, 17);
    chk("fl_miss", miss_cnt, 1);
    push(32'h610, 7'h03, 0);
    chk("fl_next_pc", head_pc, 32'h610);
    resolve(0);

    // Async reset between edges with two entries in flight
    push(32'h700, 7'h04, 1);
    push(32'h704, 7'h05, 1);
    #2 rst = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_hvalid", head_valid, 0);
    chk("ar_ready", push_ready, 1);
    chk("ar_hit", hit_cnt, 0);
    chk("ar_miss", miss_cnt, 0);
    chk("ar_ovf", overflow_err, 0);
    chk("ar_restore", restore_bhr, 0);
    tick();
    rst = 1;
    tick();
    push(32'h800, 7'h06, 1);
    chk("ar_first_pc", head_pc, 32'h800);
    chk("ar_first_cnt", count, 1);
    resolve(1);
    chk("uf_err0", underflow_err, 0);
    resolve(1);
    chk("uf_err", underflow_err, 1);
    chk("uf_count", count, 0);
    chk("uf_hit", hit_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
